battleship_board_ctrl: RTL and testbench
========================================

Name: battleship_board_ctrl

Overview:
- Parametrised board-state engine for the Battleship VGA demo.
- Replaces the hard-coded ROWS x COLS cell matrix with a live register board.
- Handles cursor movement, ship placement, shot resolution, hit counting and game-over.
- Drives the flattened board and cursor position to the VGA renderer every cycle.

Parameters:
- ROWS, 5, board rows (2..16)
- COLS, 5, board columns (2..16)
- CELL_W, 4, bits per cell on the board output (>=2; upper bits zero)
- MAX_SHIPS, 8, maximum ship cells placeable (1..ROWS*COLS)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mv_up, mv_down, mv_left, mv_right  in  1 each  single-cycle move pulses, debounced upstream
- act  in  1  single-cycle action pulse: place/remove a ship in PLACE, fire in PLAY
- start  in  1  pulse, PLACE -> PLAY
- restart  in  1  pulse, OVER -> clear board -> PLACE
- board  out  ROWS*COLS*CELL_W  flattened cells; cell (r,c) at index (r*COLS+c)*CELL_W
- cur_row  out  $clog2(ROWS)  cursor row
- cur_col  out  $clog2(COLS)  cursor column
- game_state  out  2  PLACE=0, PLAY=1, RESOLVE=2, OVER=3
- hit_pulse, miss_pulse, repeat_pulse  out  1 each  one-cycle shot result
- ship_cnt  out  $clog2(MAX_SHIPS+1)  ships placed
- hit_cnt  out  $clog2(MAX_SHIPS+1)  ships hit
- shot_cnt  out  16  valid shots fired, saturating at 0xFFFF

Behaviour:
- Cell codes: EMPTY=0, SHIP=1, MISS=2, HIT=3.
- Reset: all cells EMPTY; cursor (0,0); state PLACE; all counters 0; all pulses 0.
- Cursor moves only in PLACE and PLAY; moves are ignored in RESOLVE and OVER.
  - Wrap-around: up from row 0 -> ROWS-1; right from COLS-1 -> 0; same for down and left.
  - mv_up and mv_down together: no vertical move. mv_left and mv_right together: no horizontal move.
  - Vertical and horizontal moves in the same cycle both apply.
- PLACE, act at cursor:
  - EMPTY -> SHIP, ship_cnt+1.
  - SHIP -> EMPTY, ship_cnt-1.
  - EMPTY with ship_cnt==MAX_SHIPS: ignored.
  - Board updates on the same edge as act.
- PLACE, start: go to PLAY if ship_cnt>0; otherwise start is ignored.
- PLAY, act:
  - Latch the target from the pre-move cursor. A move in the same cycle still applies.
  - State -> RESOLVE on the next edge.
- RESOLVE (exactly one cycle), read latched target cell:
  - SHIP -> HIT, hit_cnt+1, shot_cnt+1, hit_pulse.
  - EMPTY -> MISS, shot_cnt+1, miss_pulse.
  - MISS or HIT -> unchanged, repeat_pulse, no count change.
  - Next state is OVER if the post-update hit_cnt==ship_cnt, else PLAY.
- Latency: act sampled at edge N; cell, counters and pulse update at edge N+1; pulse is high for one cycle.
- act during RESOLVE or OVER: ignored. start outside PLACE: ignored.
- OVER: board frozen. restart clears all cells and counters, sets cursor (0,0), state PLACE, in one edge.
- restart outside OVER: ignored.
- rst mid-operation (any state, including RESOLVE): full reset; no pulse emitted.
- board output is registered; cell bits above bit 1 are always 0.

Decomposition:
- Package battleship_pkg holds:
  - cell_t enum (EMPTY, SHIP, MISS, HIT);
  - state_t enum (PLACE, PLAY, RESOLVE, OVER);
  - helper constant CELL_CODE_W=2.
- One sub-module, board_cursor: wrap-around row/column counters with move-enable and clear inputs.
- FSM, cell storage and counters stay in the top module.

Test Plan:
- Reset, then 5x mv_left -> cur_col goes 4,3,2,1,0. One mv_up from row 0 -> cur_row=4. mv_up and mv_down together -> cur_row unchanged.
- Placement:
  - Place ships at (0,0) and (1,2) -> ship_cnt=2, board cells 1.
  - act again at (1,2) -> cell 0, ship_cnt=1.
  - With MAX_SHIPS=1, act on an empty cell -> ignored.
- start with ship_cnt=0 -> game_state stays 0. Place one ship, then start -> game_state=1.
- Shot sequence:
  - Fire at an empty cell -> game_state=2 for one cycle, miss_pulse at N+1, cell=2, shot_cnt=1.
  - Fire at the same cell again -> repeat_pulse, shot_cnt stays 1.
- Ships at (0,0) and (4,4); hit both -> two hit_pulses, hit_cnt=2, game_state=3. Further act and moves are ignored. restart -> all cells 0, state 0.
- Assert rst during RESOLVE -> no pulse, board cleared, cursor (0,0), state PLACE.
- Repeat the (0,0)/(4,4) hit sequence with ROWS=3, COLS=7 -> correct flat-index mapping and wrap-around.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared cell and game-state encodings for the battleship board engine.
package battleship_pkg;

    localparam int CELL_CODE_W = 2;

    typedef enum logic [CELL_CODE_W-1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        MISS  = 2'd2,
        HIT   = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        PLACE   = 2'd0,
        PLAY    = 2'd1,
        RESOLVE = 2'd2,
        OVER    = 2'd3
    } state_t;

endpackage

// File: rtl/battleship_board_ctrl_cursor.sv
// Wrap-around row/column cursor; opposing moves in one axis cancel each other.
module board_cursor #(
    parameter int ROWS = 5,
    parameter int COLS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      en,
    input  logic                      mv_up,
    input  logic                      mv_down,
    input  logic                      mv_left,
    input  logic                      mv_right,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [$clog2(COLS)-1:0]   col
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (mv_up && !mv_down) begin
                row <= (row == '0) ? ROW_LAST : row - 1'b1;
            end else if (mv_down && !mv_up) begin
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end

            if (mv_left && !mv_right) begin
                col <= (col == '0) ? COL_LAST : col - 1'b1;
            end else if (mv_right && !mv_left) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/battleship_board_ctrl.sv
// Battleship board-state engine: placement, shot resolution, counters and game-over.
module battleship_board_ctrl #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int CELL_W    = 4,
    parameter int MAX_SHIPS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mv_up,
    input  logic                              mv_down,
    input  logic                              mv_left,
    input  logic                              mv_right,
    input  logic                              act,
    input  logic                              start,
    input  logic                              restart,
    output logic [ROWS*COLS*CELL_W-1:0]       board,
    output logic [$clog2(ROWS)-1:0]           cur_row,
    output logic [$clog2(COLS)-1:0]           cur_col,
    output logic [1:0]                        game_state,
    output logic                              hit_pulse,
    output logic                              miss_pulse,
    output logic                              repeat_pulse,
    output logic [$clog2(MAX_SHIPS+1)-1:0]    ship_cnt,
    output logic [$clog2(MAX_SHIPS+1)-1:0]    hit_cnt,
    output logic [15:0]                       shot_cnt
);

    import battleship_pkg::*;

    localparam int NCELLS = ROWS * COLS;
    localparam int IDX_W  = $clog2(NCELLS);
    localparam int CNT_W  = $clog2(MAX_SHIPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SHIPS);

    state_t             state_q;
    state_t             state_d;
    cell_t              cells [NCELLS];
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   target_q;
    cell_t              cur_cell;
    cell_t              tgt_cell;
    logic [CNT_W-1:0]   hit_next;
    logic               place_set;
    logic               place_clr;
    logic               fire;
    logic               resolve;
    logic               clear;
    logic               move_en;

    board_cursor #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cursor (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .en       (move_en),
        .mv_up    (mv_up),
        .mv_down  (mv_down),
        .mv_left  (mv_left),
        .mv_right (mv_right),
        .row      (cur_row),
        .col      (cur_col)
    );

    assign cur_idx  = IDX_W'(cur_row) * IDX_W'(COLS) + IDX_W'(cur_col);
    assign cur_cell = cells[cur_idx];
    assign tgt_cell = cells[target_q];
    assign hit_next = hit_cnt + CNT_W'(tgt_cell == SHIP);
    assign move_en  = (state_q == PLACE) || (state_q == PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLACE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        place_set = 1'b0;
        place_clr = 1'b0;
        fire      = 1'b0;
        resolve   = 1'b0;
        clear     = 1'b0;
        case (state_q)
            PLACE: begin
                if (act) begin
                    if (cur_cell == SHIP) begin
                        place_clr = 1'b1;
                    end else if (cur_cell == EMPTY && ship_cnt != CNT_MAX) begin
                        place_set = 1'b1;
                    end
                end
                if (start && ship_cnt != '0) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (act) begin
                    fire    = 1'b1;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve = 1'b1;
                state_d = (hit_next == ship_cnt) ? OVER : PLAY;
            end
            OVER: begin
                if (restart) begin
                    clear   = 1'b1;
                    state_d = PLACE;
                end
            end
            default: state_d = PLACE;
        endcase
    end

    // Cell storage, counters and one-cycle shot result pulses.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NCELLS; i++) begin
                cells[i] <= EMPTY;
            end
            target_q     <= '0;
            ship_cnt     <= '0;
            hit_cnt      <= '0;
            shot_cnt     <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;

            if (place_set) begin
                cells[cur_idx] <= SHIP;
                ship_cnt       <= ship_cnt + 1'b1;
            end else if (place_clr) begin
                cells[cur_idx] <= EMPTY;
                ship_cnt       <= ship_cnt - 1'b1;
            end

            if (fire) begin
                target_q <= cur_idx;
            end

            if (resolve) begin
                case (tgt_cell)
                    SHIP: begin
                        cells[target_q] <= HIT;
                        hit_cnt         <= hit_next;
                        hit_pulse       <= 1'b1;
                        if (shot_cnt != 16'hFFFF) shot_cnt <= shot_cnt + 16'd1;
                    end
                    EMPTY: begin
                        cells[target_q] <= MISS;
                        miss_pulse      <= 1'b1;
                        if (shot_cnt != 16'hFFFF) shot_cnt <= shot_cnt + 16'd1;
                    end
                    default: repeat_pulse <= 1'b1;
                endcase
            end
        end
    end

    // Upper cell bits are tied low; renderer only decodes the 2-bit code.
    always_comb begin
        board = '0;
        for (int i = 0; i < NCELLS; i++) begin
            board[i*CELL_W +: CELL_CODE_W] = cells[i];
        end
    end

    assign game_state = state_q;

endmodule

// File: tb/tb_battleship_board_ctrl.sv
// Directed bench: vector table on a 5x5 board plus hand sequences on 5x5, MAX_SHIPS=1 and 3x7 boards.
module tb_battleship_board_ctrl;

    localparam logic [6:0] U  = 7'b1000000;
    localparam logic [6:0] D  = 7'b0100000;
    localparam logic [6:0] L  = 7'b0010000;
    localparam logic [6:0] R  = 7'b0001000;
    localparam logic [6:0] A  = 7'b0000100;
    localparam logic [6:0] S  = 7'b0000010;
    localparam logic [6:0] RS = 7'b0000001;
    localparam logic [6:0] NO = 7'b0000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
    logic act = 1'b0, start = 1'b0, restart = 1'b0;

    logic [99:0] board_a;  logic [2:0] row_a;  logic [2:0] col_a;  logic [1:0] st_a;
    logic hp_a, mp_a, rp_a;  logic [3:0] ship_a, hit_a;  logic [15:0] shot_a;

    logic [99:0] board_b;  logic [2:0] row_b;  logic [2:0] col_b;  logic [1:0] st_b;
    logic hp_b, mp_b, rp_b;  logic [0:0] ship_b, hit_b;  logic [15:0] shot_b;

    logic [83:0] board_c;  logic [1:0] row_c;  logic [2:0] col_c;  logic [1:0] st_c;
    logic hp_c, mp_c, rp_c;  logic [3:0] ship_c, hit_c;  logic [15:0] shot_c;

    int sel = 0;
    int o_row, o_col, o_st, o_ship, o_hit, o_shot, o_pulses;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    battleship_board_ctrl #(.ROWS(5), .COLS(5), .CELL_W(4), .MAX_SHIPS(8)) dut (
        .clk(clk), .rst(rst), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
        .mv_right(mv_right), .act(act), .start(start), .restart(restart),
        .board(board_a), .cur_row(row_a), .cur_col(col_a), .game_state(st_a),
        .hit_pulse(hp_a), .miss_pulse(mp_a), .repeat_pulse(rp_a),
        .ship_cnt(ship_a), .hit_cnt(hit_a), .shot_cnt(shot_a)
    );

    battleship_board_ctrl #(.ROWS(5), .COLS(5), .CELL_W(4), .MAX_SHIPS(1)) dut_m1 (
        .clk(clk), .rst(rst), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
        .mv_right(mv_right), .act(act), .start(start), .restart(restart),
        .board(board_b), .cur_row(row_b), .cur_col(col_b), .game_state(st_b),
        .hit_pulse(hp_b), .miss_pulse(mp_b), .repeat_pulse(rp_b),
        .ship_cnt(ship_b), .hit_cnt(hit_b), .shot_cnt(shot_b)
    );

    battleship_board_ctrl #(.ROWS(3), .COLS(7), .CELL_W(4), .MAX_SHIPS(8)) dut_37 (
        .clk(clk), .rst(rst), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
        .mv_right(mv_right), .act(act), .start(start), .restart(restart),
        .board(board_c), .cur_row(row_c), .cur_col(col_c), .game_state(st_c),
        .hit_pulse(hp_c), .miss_pulse(mp_c), .repeat_pulse(rp_c),
        .ship_cnt(ship_c), .hit_cnt(hit_c), .shot_cnt(shot_c)
    );

    always_comb begin
        o_row = int'(row_a);  o_col = int'(col_a);  o_st = int'(st_a);
        o_ship = int'(ship_a); o_hit = int'(hit_a); o_shot = int'(shot_a);
        o_pulses = int'({hp_a, mp_a, rp_a});
        if (sel == 1) begin
            o_row = int'(row_b);  o_col = int'(col_b);  o_st = int'(st_b);
            o_ship = int'(ship_b); o_hit = int'(hit_b); o_shot = int'(shot_b);
            o_pulses = int'({hp_b, mp_b, rp_b});
        end else if (sel == 2) begin
            o_row = int'(row_c);  o_col = int'(col_c);  o_st = int'(st_c);
            o_ship = int'(ship_c); o_hit = int'(hit_c); o_shot = int'(shot_c);
            o_pulses = int'({hp_c, mp_c, rp_c});
        end
    end

    // Whole 4-bit cell field, so stray upper bits show up as a wrong code.
    function automatic int cellAt(input int idx);
        if (sel == 1) return int'(board_b[idx*4 +: 4]);
        if (sel == 2) return int'(board_c[idx*4 +: 4]);
        return int'(board_a[idx*4 +: 4]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] in);
        @(negedge clk);
        {mv_up, mv_down, mv_left, mv_right, act, start, restart} = in;
        @(posedge clk);
        #1;
        {mv_up, mv_down, mv_left, mv_right, act, start, restart} = NO;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Ships at both corners, sunk in turn; exercises flat indexing and wrap on any board size.
    task automatic runTwoShipGame(input int rows, input int cols, input string tag);
        int last;
        last = rows * cols - 1;
        doReset();
        applyStimulus(A);
        checkOutput({tag, " ship1 cnt"}, o_ship, 1);
        checkOutput({tag, " cell0 ship"}, cellAt(0), 1);
        applyStimulus(U | L);
        checkOutput({tag, " wrap row"}, o_row, rows - 1);
        checkOutput({tag, " wrap col"}, o_col, cols - 1);
        applyStimulus(A);
        checkOutput({tag, " ship2 cnt"}, o_ship, 2);
        checkOutput({tag, " last cell ship"}, cellAt(last), 1);
        checkOutput({tag, " row0 lastcol empty"}, cellAt(cols - 1), 0);
        applyStimulus(S);
        checkOutput({tag, " start"}, o_st, 1);
        applyStimulus(A);
        checkOutput({tag, " resolve1"}, o_st, 2);
        applyStimulus(NO);
        checkOutput({tag, " hit1 pulse"}, o_pulses, 3'b100);
        checkOutput({tag, " hit1 cnt"}, o_hit, 1);
        checkOutput({tag, " hit1 state"}, o_st, 1);
        checkOutput({tag, " last cell hit"}, cellAt(last), 3);
        applyStimulus(D | R);
        checkOutput({tag, " wrap back row"}, o_row, 0);
        checkOutput({tag, " wrap back col"}, o_col, 0);
        checkOutput({tag, " pulse cleared"}, o_pulses, 0);
        applyStimulus(A);
        applyStimulus(NO);
        checkOutput({tag, " hit2 pulse"}, o_pulses, 3'b100);
        checkOutput({tag, " hit2 cnt"}, o_hit, 2);
        checkOutput({tag, " over state"}, o_st, 3);
        checkOutput({tag, " shots"}, o_shot, 2);
        checkOutput({tag, " cell0 hit"}, cellAt(0), 3);
        applyStimulus(A | D);
        checkOutput({tag, " over frozen state"}, o_st, 3);
        checkOutput({tag, " over frozen row"}, o_row, 0);
        checkOutput({tag, " over no pulse"}, o_pulses, 0);
        checkOutput({tag, " over shots"}, o_shot, 2);
        applyStimulus(RS);
        checkOutput({tag, " restart state"}, o_st, 0);
        checkOutput({tag, " restart cell0"}, cellAt(0), 0);
        checkOutput({tag, " restart last"}, cellAt(last), 0);
        checkOutput({tag, " restart hits"}, o_hit, 0);
        checkOutput({tag, " restart ships"}, o_ship, 0);
    endtask

    typedef struct {
        logic [6:0] in;
        int row, col, st, ship, hit, shot, pulses, cidx, ccell;
    } vec_t;

    vec_t vecs [31];

    initial begin
        // in, row, col, state, ship, hit, shot, {hit,miss,repeat}, cell idx, cell code
        vecs[0]  = '{L,      0, 4, 0, 0, 0, 0, 0,      0, 0};
        vecs[1]  = '{L,      0, 3, 0, 0, 0, 0, 0,      0, 0};
        vecs[2]  = '{L,      0, 2, 0, 0, 0, 0, 0,      0, 0};
        vecs[3]  = '{L,      0, 1, 0, 0, 0, 0, 0,      0, 0};
        vecs[4]  = '{L,      0, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[5]  = '{U,      4, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[6]  = '{U | D,  4, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[7]  = '{L | R,  4, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[8]  = '{D,      0, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[9]  = '{S | RS, 0, 0, 0, 0, 0, 0, 0,      0, 0};
        vecs[10] = '{A,      0, 0, 0, 1, 0, 0, 0,      0, 1};
        vecs[11] = '{D | R,  1, 1, 0, 1, 0, 0, 0,      0, 1};
        vecs[12] = '{R,      1, 2, 0, 1, 0, 0, 0,      7, 0};
        vecs[13] = '{A,      1, 2, 0, 2, 0, 0, 0,      7, 1};
        vecs[14] = '{A,      1, 2, 0, 1, 0, 0, 0,      7, 0};
        vecs[15] = '{S,      1, 2, 1, 1, 0, 0, 0,      0, 1};
        vecs[16] = '{A | R,  1, 3, 2, 1, 0, 0, 0,      7, 0};
        vecs[17] = '{D,      1, 3, 1, 1, 0, 1, 3'b010, 7, 2};
        vecs[18] = '{NO,     1, 3, 1, 1, 0, 1, 0,      7, 2};
        vecs[19] = '{L,      1, 2, 1, 1, 0, 1, 0,      7, 2};
        vecs[20] = '{A,      1, 2, 2, 1, 0, 1, 0,      7, 2};
        vecs[21] = '{NO,     1, 2, 1, 1, 0, 1, 3'b001, 7, 2};
        vecs[22] = '{U,      0, 2, 1, 1, 0, 1, 0,      0, 1};
        vecs[23] = '{L,      0, 1, 1, 1, 0, 1, 0,      0, 1};
        vecs[24] = '{L,      0, 0, 1, 1, 0, 1, 0,      0, 1};
        vecs[25] = '{A,      0, 0, 2, 1, 0, 1, 0,      0, 1};
        vecs[26] = '{NO,     0, 0, 3, 1, 1, 2, 3'b100, 0, 3};
        vecs[27] = '{A | R,  0, 0, 3, 1, 1, 2, 0,      0, 3};
        vecs[28] = '{S,      0, 0, 3, 1, 1, 2, 0,      7, 2};
        vecs[29] = '{RS,     0, 0, 0, 0, 0, 0, 0,      7, 0};
        vecs[30] = '{NO,     0, 0, 0, 0, 0, 0, 0,      0, 0};

        sel = 0;
        doReset();
        checkOutput("reset row", o_row, 0);
        checkOutput("reset col", o_col, 0);
        checkOutput("reset state", o_st, 0);
        checkOutput("reset ships", o_ship, 0);
        checkOutput("reset hits", o_hit, 0);
        checkOutput("reset shots", o_shot, 0);
        checkOutput("reset pulses", o_pulses, 0);
        checkOutput("reset board", int'(board_a != '0), 0);

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d row", i), o_row, vecs[i].row);
            checkOutput($sformatf("vec%0d col", i), o_col, vecs[i].col);
            checkOutput($sformatf("vec%0d state", i), o_st, vecs[i].st);
            checkOutput($sformatf("vec%0d ships", i), o_ship, vecs[i].ship);
            checkOutput($sformatf("vec%0d hits", i), o_hit, vecs[i].hit);
            checkOutput($sformatf("vec%0d shots", i), o_shot, vecs[i].shot);
            checkOutput($sformatf("vec%0d pulses", i), o_pulses, vecs[i].pulses);
            checkOutput($sformatf("vec%0d cell%0d", i, vecs[i].cidx), cellAt(vecs[i].cidx), vecs[i].ccell);
        end

        sel = 0;
        runTwoShipGame(5, 5, "5x5");

        // Reset while the shot is resolving must drop the pending result.
        sel = 0;
        doReset();
        applyStimulus(A);
        applyStimulus(S);
        applyStimulus(A);
        checkOutput("rstres in resolve", o_st, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstres pulses", o_pulses, 0);
        checkOutput("rstres state", o_st, 0);
        checkOutput("rstres cell0", cellAt(0), 0);
        checkOutput("rstres ships", o_ship, 0);
        checkOutput("rstres shots", o_shot, 0);
        checkOutput("rstres row", o_row, 0);
        checkOutput("rstres col", o_col, 0);
        applyStimulus(NO);
        checkOutput("rstres later pulses", o_pulses, 0);
        checkOutput("rstres later state", o_st, 0);

        sel = 1;
        doReset();
        applyStimulus(A);
        checkOutput("max1 first ship", o_ship, 1);
        applyStimulus(R);
        applyStimulus(A);
        checkOutput("max1 full ignored cnt", o_ship, 1);
        checkOutput("max1 full ignored cell", cellAt(1), 0);
        checkOutput("max1 first cell kept", cellAt(0), 1);

        sel = 2;
        runTwoShipGame(3, 7, "3x7");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
